// File: rtl/ifft_frame_loader_if.sv
// Stream-in / frame-out bundle for the IFFT frame loader.
// The loader takes the slave side; the source/sink takes master.
interface ifft_frame_loader_if #(
  parameter int NUM_POINT = 8,
  parameter int DATA_W    = 32
);

  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_W-1:0]                 in_real;
  logic [DATA_W-1:0]                 in_imag;
  logic                              in_last;

  logic                              frame_valid;
  logic                              frame_ready;
  logic [NUM_POINT-1:0][DATA_W-1:0]  frame_real;
  logic [NUM_POINT-1:0][DATA_W-1:0]  frame_imag;
  logic                              frame_short;
  logic [15:0]                       frame_count;

  modport master (
    output in_valid,
    output in_real,
    output in_imag,
    output in_last,
    output frame_ready,
    input  in_ready,
    input  frame_valid,
    input  frame_real,
    input  frame_imag,
    input  frame_short,
    input  frame_count
  );

  modport slave (
    input  in_valid,
    input  in_real,
    input  in_imag,
    input  in_last,
    input  frame_ready,
    output in_ready,
    output frame_valid,
    output frame_real,
    output frame_imag,
    output frame_short,
    output frame_count
  );

endinterface

// File: rtl/ifft_frame_loader.sv
// Serial-to-parallel frame loader ahead of the 8-point IFFT core.
// Ping-pong banks: one loads while the other is held for the core.
module ifft_frame_loader #(
  parameter int NUM_POINT = 8,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 3
) (
  input  logic               clock,
  input  logic               reset,
  ifft_frame_loader_if.slave s
);

  typedef logic [NUM_POINT-1:0][DATA_W-1:0] bank_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  bank_t            re_q [2];
  bank_t            re_d [2];
  bank_t            im_q [2];
  bank_t            im_d [2];
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic [1:0]       short_q;
  logic [1:0]       short_d;
  logic             wr_sel_q;
  logic             wr_sel_d;
  logic             rd_sel_q;
  logic             rd_sel_d;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] wr_idx_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;

  logic accept;
  logic consume;
  logic close;

  // Handshake decodes depend on registered state only.
  assign s.in_ready    = ~full_q[wr_sel_q];
  assign s.frame_valid = full_q[rd_sel_q];
  assign s.frame_real  = re_q[rd_sel_q];
  assign s.frame_imag  = im_q[rd_sel_q];
  assign s.frame_short = short_q[rd_sel_q];
  assign s.frame_count = cnt_q;

  assign accept  = s.in_valid & ~full_q[wr_sel_q];
  assign consume = full_q[rd_sel_q] & s.frame_ready;
  assign close   = accept & (s.in_last | (wr_idx_q == LAST_IDX));

  // Next state: load into the write bank, drain and zero the read bank.
  // Accept needs !full and consume needs full, so they never collide.
  always_comb begin
    re_d     = re_q;
    im_d     = im_q;
    full_d   = full_q;
    short_d  = short_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;

    if (accept) begin
      re_d[wr_sel_q][wr_idx_q] = s.in_real;
      im_d[wr_sel_q][wr_idx_q] = s.in_imag;
      if (close) begin
        full_d[wr_sel_q]  = 1'b1;
        short_d[wr_sel_q] = (wr_idx_q != LAST_IDX);
        wr_sel_d          = ~wr_sel_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_ONE;
      end
    end

    // Zeroing here is what pads short frames later on.
    if (consume) begin
      full_d[rd_sel_q]  = 1'b0;
      short_d[rd_sel_q] = 1'b0;
      re_d[rd_sel_q]    = '0;
      im_d[rd_sel_q]    = '0;
      rd_sel_d          = ~rd_sel_q;
      cnt_d             = cnt_q + 16'd1;
    end
  end

  // State register with synchronous reset discarding any partial frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      re_q[0]  <= '0;
      re_q[1]  <= '0;
      im_q[0]  <= '0;
      im_q[1]  <= '0;
      full_q   <= '0;
      short_q  <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      re_q[0]  <= re_d[0];
      re_q[1]  <= re_d[1];
      im_q[0]  <= im_d[0];
      im_q[1]  <= im_d[1];
      full_q   <= full_d;
      short_q  <= short_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifft_frame_loader.sv
// Bench for ifft_frame_loader: directed scenarios plus a random
// stream checked against a frame-queue reference model.
module tb_ifft_frame_loader;

  localparam int NP = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifft_frame_loader_if #(.NUM_POINT(NP), .DATA_W(DW)) b ();

  ifft_frame_loader #(
    .NUM_POINT(NP),
    .DATA_W   (DW),
    .IDX_W    (3)
  ) dut (
    .clock(clk),
    .reset(rst),
    .s    (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re [NP];
    logic [31:0] im [NP];
    bit          sh;
  } frm_t;

  frm_t        fq [$];
  frm_t        cur;
  int          cur_n;
  logic [15:0] m_cnt;
  bit          acc_o;
  int          n_run;
  int          n_fail;

  function automatic void m_clear_cur();
    for (int k = 0; k < NP; k++) begin
      cur.re[k] = '0;
      cur.im[k] = '0;
    end
    cur.sh = 1'b0;
    cur_n  = 0;
  endfunction

  function automatic void m_reset();
    fq.delete();
    m_clear_cur();
    m_cnt = '0;
  endfunction

  task automatic drv(bit v, bit l, logic [31:0] r,
                     logic [31:0] i, bit fr);
    b.in_valid    = v;
    b.in_last     = l;
    b.in_real     = r;
    b.in_imag     = i;
    b.frame_ready = fr;
  endtask

  // One clock: the model applies the same handshake the DUT sees.
  task automatic tick();
    bit          acc;
    bit          con;
    bit          lst;
    logic [31:0] r;
    logic [31:0] i;
    acc = b.in_valid && (fq.size() < 2);
    con = (fq.size() > 0) && b.frame_ready;
    lst = b.in_last;
    r   = b.in_real;
    i   = b.in_imag;
    @(posedge clk);
    if (rst) begin
      m_reset();
      acc = 1'b0;
    end else begin
      if (con) begin
        fq.delete(0);
        m_cnt++;
      end
      if (acc) begin
        cur.re[cur_n] = r;
        cur.im[cur_n] = i;
        cur_n++;
        if (lst || cur_n == NP) begin
          cur.sh = (cur_n != NP);
          fq.push_back(cur);
          m_clear_cur();
        end
      end
    end
    acc_o = acc;
    #1;
  endtask

  task automatic test_reset();
    drv(1'b1, 1'b0, 32'h1234_5678, 32'h9abc_def0, 1'b0);
    rst = 1'b1;
    tick();
    n_run++;
    if (b.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset in_ready got %b want 1", b.in_ready);
    end
    n_run++;
    if (b.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset frame_valid got %b want 0", b.frame_valid);
    end
    n_run++;
    if (b.frame_short !== 1'b0) begin
      n_fail++;
      $display("FAIL reset frame_short got %b want 0", b.frame_short);
    end
    n_run++;
    if (b.frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset frame_count got %h want 0", b.frame_count);
    end
    n_run++;
    if (b.frame_real !== '0 || b.frame_imag !== '0) begin
      n_fail++;
      $display("FAIL reset frame_data got %h/%h want 0",
               b.frame_real, b.frame_imag);
    end
    rst = 1'b0;
    drv(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_stream();
    bit cl;
    for (int k = 0; k < 16; k++) begin
      cl = (k == 7) || (k == 15);
      drv(1'b1, cl, 32'(k) << 16, '0, 1'b1);
      tick();
      n_run++;
      if (b.frame_valid !== cl) begin
        n_fail++;
        $display("FAIL stream valid s%0d got %b want %b",
                 k, b.frame_valid, cl);
      end
      if (cl) begin
        for (int j = 0; j < NP; j++) begin
          n_run++;
          if (b.frame_real[j] !== (32'(k - 7 + j) << 16)) begin
            n_fail++;
            $display("FAIL stream real[%0d] s%0d got %h want %h", j, k,
                     b.frame_real[j], 32'(k - 7 + j) << 16);
          end
        end
        n_run++;
        if (b.frame_short !== 1'b0) begin
          n_fail++;
          $display("FAIL stream short got %b want 0", b.frame_short);
        end
      end
    end
    drv(1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    n_run++;
    if (b.frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL stream count got %0d want 2", b.frame_count);
    end
  endtask

  task automatic test_backpressure();
    int kk;
    kk = 0;
    for (int c = 0; c < 20; c++) begin
      drv(1'b1, 1'b0, 32'(kk) << 16, 32'(kk), 1'b0);
      tick();
      if (acc_o) kk++;
      if (c >= 15) begin
        n_run++;
        if (b.in_ready !== 1'b0 || b.frame_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp full c%0d got rdy=%b vld=%b want 0/1",
                   c, b.in_ready, b.frame_valid);
        end
        n_run++;
        if (b.frame_real[3] !== 32'h0003_0000) begin
          n_fail++;
          $display("FAIL bp hold real[3] got %h want 00030000",
                   b.frame_real[3]);
        end
      end
    end
    drv(1'b1, 1'b0, 32'(kk) << 16, 32'(kk), 1'b1);
    tick();
    n_run++;
    if (b.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp release in_ready got %b want 1", b.in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      drv(1'b1, 1'b0, 32'(kk) << 16, 32'(kk), 1'b0);
      tick();
      if (acc_o) kk++;
    end
    n_run++;
    if (b.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp refill in_ready got %b want 0", b.in_ready);
    end
    drv(1'b0, 1'b0, '0, '0, 1'b1);
    for (int f = 1; f <= 2; f++) begin
      for (int j = 0; j < NP; j++) begin
        n_run++;
        if (b.frame_real[j] !== (32'(f * 8 + j) << 16) ||
            b.frame_imag[j] !== 32'(f * 8 + j)) begin
          n_fail++;
          $display("FAIL bp drain f%0d p%0d got %h/%h want %h/%h",
                   f, j, b.frame_real[j], b.frame_imag[j],
                   32'(f * 8 + j) << 16, 32'(f * 8 + j));
        end
      end
      tick();
    end
    n_run++;
    if (b.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp empty valid got %b want 0", b.frame_valid);
    end
  endtask

  task automatic test_short();
    for (int k = 1; k <= 3; k++) begin
      drv(1'b1, k == 3, 32'(k) << 16, '0, 1'b0);
      tick();
    end
    n_run++;
    if (b.frame_valid !== 1'b1 || b.frame_short !== 1'b1) begin
      n_fail++;
      $display("FAIL short flags got vld=%b sh=%b want 1/1",
               b.frame_valid, b.frame_short);
    end
    for (int j = 0; j < NP; j++) begin
      n_run++;
      if (b.frame_real[j] !== (j < 3 ? 32'(j + 1) << 16 : 32'd0)) begin
        n_fail++;
        $display("FAIL short real[%0d] got %h want %h", j,
                 b.frame_real[j], j < 3 ? 32'(j + 1) << 16 : 32'd0);
      end
    end
    for (int k = 0; k < NP; k++) begin
      drv(1'b1, 1'b0, 32'h100 + 32'(k), 32'(k), 1'b1);
      tick();
    end
    n_run++;
    if (b.frame_valid !== 1'b1 || b.frame_short !== 1'b0) begin
      n_fail++;
      $display("FAIL short next got vld=%b sh=%b want 1/0",
               b.frame_valid, b.frame_short);
    end
    for (int j = 0; j < NP; j++) begin
      n_run++;
      if (b.frame_real[j] !== 32'h100 + 32'(j)) begin
        n_fail++;
        $display("FAIL short next real[%0d] got %h want %h", j,
                 b.frame_real[j], 32'h100 + 32'(j));
      end
    end
    drv(1'b0, 1'b0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_stale();
    for (int k = 0; k < NP; k++) begin
      drv(1'b1, 1'b0, 32'haaaa_0000 + 32'(k), 32'h5555, 1'b0);
      tick();
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 2; k++) begin
        drv(1'b1, k == 1, 32'h50 + 32'(f * 2 + k), 32'(f), 1'b1);
        tick();
      end
      n_run++;
      if (b.frame_short !== 1'b1) begin
        n_fail++;
        $display("FAIL stale short f%0d got %b want 1", f, b.frame_short);
      end
      for (int j = 0; j < NP; j++) begin
        n_run++;
        if (b.frame_real[j] !==
            (j < 2 ? 32'h50 + 32'(f * 2 + j) : 32'd0) ||
            b.frame_imag[j] !== (j < 2 ? 32'(f) : 32'd0)) begin
          n_fail++;
          $display("FAIL stale f%0d p%0d got %h/%h", f, j,
                   b.frame_real[j], b.frame_imag[j]);
        end
      end
    end
    drv(1'b0, 1'b0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < NP + 5; k++) begin
      drv(1'b1, 1'b0, 32'hdead_0000 + 32'(k), '1, 1'b0);
      tick();
    end
    rst = 1'b1;
    drv(1'b1, 1'b0, 32'hbad, 32'hbad, 1'b1);
    tick();
    rst = 1'b0;
    n_run++;
    if (b.frame_valid !== 1'b0 || b.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid got vld=%b rdy=%b want 0/1",
               b.frame_valid, b.in_ready);
    end
    n_run++;
    if (b.frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid count got %0d want 0", b.frame_count);
    end
    for (int k = 0; k < NP; k++) begin
      drv(1'b1, 1'b0, 32'h7000 + 32'(k), 32'h10 * 32'(k), 1'b0);
      tick();
    end
    n_run++;
    if (b.frame_valid !== 1'b1 || b.frame_short !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid frame got vld=%b sh=%b want 1/0",
               b.frame_valid, b.frame_short);
    end
    for (int j = 0; j < NP; j++) begin
      n_run++;
      if (b.frame_real[j] !== 32'h7000 + 32'(j) ||
          b.frame_imag[j] !== 32'h10 * 32'(j)) begin
        n_fail++;
        $display("FAIL rstmid p%0d got %h/%h want %h/%h", j,
                 b.frame_real[j], b.frame_imag[j],
                 32'h7000 + 32'(j), 32'h10 * 32'(j));
      end
    end
    drv(1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    n_run++;
    if (b.frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL rstmid count1 got %0d want 1", b.frame_count);
    end
  endtask

  task automatic test_random();
    int pr;
    int bad;
    pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) pr = $urandom_range(5, 100);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
          $urandom, $urandom, $urandom_range(0, 99) < pr);
      tick();
      n_run++;
      if (b.in_ready !== (fq.size() < 2) ||
          b.frame_valid !== (fq.size() > 0) ||
          b.frame_count !== m_cnt) begin
        n_fail++;
        $display("FAIL rand ctl c%0d got rdy=%b vld=%b cnt=%h want %b/%b/%h",
                 c, b.in_ready, b.frame_valid, b.frame_count,
                 fq.size() < 2, fq.size() > 0, m_cnt);
      end
      if (fq.size() > 0) begin
        bad = 0;
        for (int j = 0; j < NP; j++) begin
          if (b.frame_real[j] !== fq[0].re[j] ||
              b.frame_imag[j] !== fq[0].im[j]) bad++;
        end
        n_run++;
        if (bad != 0 || b.frame_short !== fq[0].sh) begin
          n_fail++;
          $display("FAIL rand data c%0d got %0d bad pts sh=%b want 0/%b",
                   c, bad, b.frame_short, fq[0].sh);
        end
      end
    end
    drv(1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    tick();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(1'b1, 1'b1, 32'h0001_0000, 32'h2, 1'b1);
    for (int c = 0; c < 65536; c++) tick();
    n_run++;
    if (b.frame_count !== 16'hffff || b.frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap pre got cnt=%h vld=%b want ffff/1",
               b.frame_count, b.frame_valid);
    end
    drv(1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    n_run++;
    if (b.frame_count !== 16'h0000 || b.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap got cnt=%h vld=%b want 0000/0",
               b.frame_count, b.frame_valid);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    m_reset();
    drv(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_short();
    test_stale();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
